// File: rtl/vga_line_scheduler_if.sv
// rtl/vga_line_scheduler_if.sv - scan-buffer read port and VGA sync bundle of the line scheduler
interface vga_line_scheduler_if;
  logic [10:0] addrread;
  logic [9:0]  totalhor;
  logic        locked;
  logic        scaneffect;
  logic        hsync;
  logic        vsync;

  modport master (output addrread, totalhor, locked, scaneffect, hsync, vsync);
  modport slave  (input  addrread, totalhor, locked, scaneffect, hsync, vsync);
endinterface

// File: rtl/vga_line_scheduler.sv
// rtl/vga_line_scheduler.sv - source line period lock, scan-buffer read sequencing and VGA sync generation
module vga_line_scheduler #(
  parameter int HSYNC_W    = 80,
  parameter int VSYNC_W    = 2743,
  parameter int MIN_LINE   = 128,
  parameter int TOL        = 2,
  parameter int LOCK_LINES = 4,
  parameter int MISS_MAX   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hsync_ext_n,
  input  logic                 vsync_ext_n,
  vga_line_scheduler_if.master vga
);
  localparam int MW = $clog2(LOCK_LINES + 1);
  localparam int XW = $clog2(MISS_MAX + 1);
  localparam logic [11:0]   MIN_P     = 12'(MIN_LINE);
  localparam logic [11:0]   MAX_P     = 12'd2046;
  localparam logic [11:0]   TOL_P     = 12'(TOL);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_LINES - 1);
  localparam logic [XW-1:0] MISS_LAST = XW'(MISS_MAX - 1);
  localparam logic [9:0]    HS_W      = 10'(HSYNC_W);
  localparam logic [15:0]   VS_W      = 16'(VSYNC_W);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t        state, state_nx;
  logic          armed, armed_nx;
  logic [10:0]   ref_p, ref_nx;
  logic [MW-1:0] mcnt, mcnt_nx;
  logic [XW-1:0] miss, miss_nx;
  logic [9:0]    totalhor, totalhor_nx;

  logic [2:0]  hs_sync, vs_sync;
  logic        hedge, vedge;
  logic [10:0] pcnt;
  logic [11:0] period, diff, adiff;
  logic        p_valid, p_match, timeout, is_locked;

  logic        bank, scaneffect, hsync_q, vsync_q;
  logic [9:0]  addr;
  logic [15:0] vcnt;

  // Two flops resynchronise the pins; the third only exists to find the falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_sync <= 3'b111;
      vs_sync <= 3'b111;
    end else begin
      hs_sync <= {hs_sync[1:0], hsync_ext_n};
      vs_sync <= {vs_sync[1:0], vsync_ext_n};
    end
  end

  assign hedge = hs_sync[2] & ~hs_sync[1];
  assign vedge = vs_sync[2] & ~vs_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  pcnt <= '0;
    else if (hedge)           pcnt <= '0;
    else if (pcnt != 11'h7FF) pcnt <= pcnt + 11'd1;
  end

  assign period    = {1'b0, pcnt} + 12'd1;
  assign diff      = period - {1'b0, ref_p};
  assign adiff     = diff[11] ? (12'd0 - diff) : diff;
  assign p_valid   = (period >= MIN_P) && (period <= MAX_P);
  assign p_match   = p_valid && (adiff <= TOL_P);
  // An edge arriving exactly at saturation is measured normally, so it can arm the search.
  assign timeout   = (&pcnt) && !hedge;
  assign is_locked = (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SEARCH;
      armed    <= 1'b0;
      ref_p    <= '0;
      mcnt     <= '0;
      miss     <= '0;
      totalhor <= '0;
    end else begin
      state    <= state_nx;
      armed    <= armed_nx;
      ref_p    <= ref_nx;
      mcnt     <= mcnt_nx;
      miss     <= miss_nx;
      totalhor <= totalhor_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    armed_nx    = armed;
    ref_nx      = ref_p;
    mcnt_nx     = mcnt;
    miss_nx     = miss;
    totalhor_nx = totalhor;
    if (timeout) begin
      state_nx = SEARCH;
      armed_nx = 1'b0;
    end else if (hedge) begin
      case (state)
        SEARCH: begin
          if (!armed) begin
            armed_nx = 1'b1;
          end else if (p_valid) begin
            ref_nx   = period[10:0];
            mcnt_nx  = MW'(1);
            state_nx = MEASURE;
          end
        end
        MEASURE: begin
          if (!p_valid) begin
            state_nx = SEARCH;
          end else if (p_match) begin
            mcnt_nx = mcnt + MW'(1);
            if (mcnt == LOCK_LAST) begin
              state_nx    = LOCKED;
              miss_nx     = '0;
              totalhor_nx = ref_p[10:1] - 10'd1;
            end
          end else begin
            ref_nx  = period[10:0];
            mcnt_nx = MW'(1);
          end
        end
        LOCKED: begin
          if (p_match) begin
            miss_nx = '0;
          end else if (miss == MISS_LAST) begin
            miss_nx  = '0;
            state_nx = SEARCH;
          end else begin
            miss_nx = miss + XW'(1);
          end
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  // Each source line is read twice: scaneffect marks the second VGA pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank       <= 1'b0;
      addr       <= '0;
      scaneffect <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      vcnt       <= '0;
    end else begin
      if (hedge) begin
        bank       <= ~bank;
        addr       <= '0;
        scaneffect <= 1'b0;
      end else if (addr == totalhor) begin
        addr       <= '0;
        scaneffect <= ~scaneffect;
      end else begin
        addr <= addr + 10'd1;
      end
      hsync_q <= ~(is_locked && (addr < HS_W));
      if (!is_locked)                   vcnt <= '0;
      else if (vedge && vcnt == 16'd0)  vcnt <= VS_W;
      else if (vcnt != 16'd0)           vcnt <= vcnt - 16'd1;
      vsync_q <= ~(is_locked && (vcnt != 16'd0));
    end
  end

  assign vga.addrread   = {bank, addr};
  assign vga.totalhor   = totalhor;
  assign vga.locked     = is_locked;
  assign vga.scaneffect = scaneffect;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
endmodule

// File: tb/tb_vga_line_scheduler.sv
// tb/tb_vga_line_scheduler.sv - line-event model and directed lock/sync scenarios for vga_line_scheduler
module tb_vga_line_scheduler;
  logic clk = 1'b0;
  logic rst;
  logic hsync_ext_n;
  logic vsync_ext_n;

  vga_line_scheduler_if bus();

  vga_line_scheduler dut (
    .clk(clk), .rst(rst), .hsync_ext_n(hsync_ext_n), .vsync_ext_n(vsync_ext_n), .vga(bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;

  int hper = 1536, hlow = 100, hphase = 0, hfall_cnt = 0, hfall_cyc = 0;
  bit h_run = 0;

  int m_mode, m_armed, m_ref, m_mcnt, m_miss, m_T, m_bank, m_lasth;
  int m_addr, m_se, m_locked, m_vstart, m_hs, m_vs;
  bit hp1, hp2, hp3, vp1, vp2, vp3;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_armed = 0; m_ref = 0; m_mcnt = 0; m_miss = 0; m_T = 0;
    m_bank = 0; m_lasth = 0; m_addr = 0; m_se = 0; m_locked = 0;
    m_vstart = -1; m_hs = 1; m_vs = 1;
    hp1 = 1; hp2 = 1; hp3 = 1; vp1 = 1; vp2 = 1; vp3 = 1;
    cyc = 0;
  endtask

  // Event-level view: lines are spans between detected edges; addresses follow from elapsed cycles.
  task automatic model_step(input int n);
    bit hedge, vedge, valid, match, vact;
    int since, p, d, pl, pa, k;
    hedge = hp3 && !hp2;
    vedge = vp3 && !vp2;
    hp3 = hp2; hp2 = hp1; hp1 = hsync_ext_n;
    vp3 = vp2; vp2 = vp1; vp1 = vsync_ext_n;
    pl = m_locked;
    pa = m_addr;
    m_hs = (pl != 0 && pa < 80) ? 0 : 1;
    vact = (m_vstart >= 0) && (n - 1 < m_vstart + 2743);
    m_vs = (pl != 0 && vact) ? 0 : 1;
    if (pl == 0) m_vstart = -1;
    else if (vedge && !vact) m_vstart = n;
    since = n - 1 - m_lasth;
    if (!hedge && since >= 2047) begin
      m_mode = 0;
      m_armed = 0;
    end else if (hedge) begin
      p = ((since > 2047) ? 2047 : since) + 1;
      valid = (p >= 128) && (p <= 2046);
      d = p - m_ref;
      if (d < 0) d = -d;
      match = valid && (d <= 2);
      case (m_mode)
        0: begin
          if (m_armed == 0) m_armed = 1;
          else if (valid) begin m_ref = p; m_mcnt = 1; m_mode = 1; end
        end
        1: begin
          if (!valid) m_mode = 0;
          else if (match) begin
            m_mcnt++;
            if (m_mcnt == 4) begin m_mode = 2; m_miss = 0; m_T = m_ref / 2 - 1; end
          end else begin m_ref = p; m_mcnt = 1; end
        end
        default: begin
          if (match) m_miss = 0;
          else begin m_miss++; if (m_miss == 3) m_mode = 0; end
        end
      endcase
      m_lasth = n;
      m_bank ^= 1;
    end
    m_locked = (m_mode == 2) ? 1 : 0;
    k = n - m_lasth;
    m_addr = k % (m_T + 1);
    m_se = (k / (m_T + 1)) % 2;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      if (rst) model_reset();
      else begin
        cyc++;
        model_step(cyc);
      end
      nvec++;
      if (bus.addrread != 11'(m_bank * 1024 + m_addr) || bus.totalhor != 10'(m_T) ||
          bus.locked != 1'(m_locked) || bus.scaneffect != 1'(m_se) ||
          bus.hsync != 1'(m_hs) || bus.vsync != 1'(m_vs)) begin
        nfail++;
        $display("FAIL cycle %0d outputs: got addr=%0d th=%0d lk=%0d se=%0d hs=%0d vs=%0d, expected addr=%0d th=%0d lk=%0d se=%0d hs=%0d vs=%0d",
                 cyc, bus.addrread, bus.totalhor, bus.locked, bus.scaneffect, bus.hsync, bus.vsync,
                 m_bank * 1024 + m_addr, m_T, m_locked, m_se, m_hs, m_vs);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (h_run) begin
        if (hphase == 0) begin
          hsync_ext_n = 1'b0;
          hfall_cnt++;
          hfall_cyc = cyc;
        end else if (hphase == hlow) begin
          hsync_ext_n = 1'b1;
        end
        hphase++;
        if (hphase >= hper) hphase = 0;
      end else begin
        hsync_ext_n = 1'b1;
        hphase = 0;
      end
    end
  end

  task automatic wait_fall(input int target, output int fe);
    int i;
    i = 0;
    while (hfall_cnt < target && i < 40000) begin
      @(negedge clk);
      i++;
    end
    if (hfall_cnt < target) begin
      nvec++; nfail++;
      $display("FAIL wait_fall: got %0d falls, expected %0d", hfall_cnt, target);
    end
    fe = hfall_cyc;
  endtask

  task automatic wait_lock(input bit val, input int bound, output int lc);
    lc = -1;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #2;
      if (bus.locked == val) begin
        lc = cyc;
        break;
      end
    end
    if (lc < 0) begin
      nvec++; nfail++;
      $display("FAIL wait_lock: locked never became %0d, expected within %0d cycles", val, bound);
    end
  endtask

  initial begin
    int fe, lc, fb, cnt_a, cnt_b, cnt_c, b0;
    rst = 1'b1;
    hsync_ext_n = 1'b1;
    vsync_ext_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_addrread", bus.addrread, 0);
    chk("rst_totalhor", bus.totalhor, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_scaneffect", bus.scaneffect, 0);
    chk("rst_hsync", bus.hsync, 1);
    chk("rst_vsync", bus.vsync, 1);
    @(negedge clk);
    rst = 1'b0;

    // Lock at 1536 on the fifth edge.
    hper = 1536; hlow = 100; h_run = 1;
    wait_fall(4, fe);
    repeat (6) @(posedge clk);
    #2;
    chk("t1_unlocked_after_4_edges", bus.locked, 0);
    wait_fall(5, fe);
    wait_lock(1'b1, 1600, lc);
    chk("t1_lock_latency", lc - fe, 3);
    chk("t1_totalhor", bus.totalhor, 767);

    // One full source line: two 80-cycle hsync pulses, 768 second-pass cycles, bank flips.
    repeat (10) @(negedge clk);
    cnt_a = 0; cnt_b = 0; b0 = bus.addrread[10];
    for (int i = 0; i < 1536; i++) begin
      @(negedge clk);
      if (!bus.hsync) cnt_a++;
      if (bus.scaneffect) cnt_b++;
    end
    chk("t4_hsync_low_per_line", cnt_a, 160);
    chk("t4_second_pass_cycles", cnt_b, 768);
    chk("t4_bank_toggled", bus.addrread[10], 1 - b0);

    // VGA vsync pulse with a retrigger attempt inside it.
    cnt_a = 0; cnt_c = 0;
    for (int i = 0; i < 5400; i++) begin
      @(negedge clk);
      if (!bus.vsync) cnt_a++;
      if (!bus.locked) cnt_c++;
      if (i == 100) vsync_ext_n = 1'b0;
      else if (i == 600) vsync_ext_n = 1'b1;
      else if (i == 1100) vsync_ext_n = 1'b0;
      else if (i == 5100) vsync_ext_n = 1'b1;
    end
    chk("t5_vsync_low_cycles", cnt_a, 2743);
    chk("t5_locked_held", cnt_c, 0);

    // Jitter within tolerance, then three out-of-tolerance lines.
    wait_fall(hfall_cnt + 1, fe);
    hper = 1538;
    for (int i = 0; i < 3; i++) begin
      wait_fall(hfall_cnt + 1, fe);
      hper = (i % 2 == 0) ? 1534 : 1538;
    end
    wait_fall(hfall_cnt + 1, fe);
    hper = 1540;
    repeat (4) @(posedge clk);
    #2;
    chk("t2_locked_with_jitter", bus.locked, 1);
    wait_fall(hfall_cnt + 3, fe);
    wait_lock(1'b0, 1600, lc);
    chk("t2_unlock_latency", lc - fe, 3);
    @(posedge clk);
    #2;
    chk("t2_hsync_released", bus.hsync, 1);
    chk("t2_vsync_released", bus.vsync, 1);
    wait_lock(1'b1, 8000, lc);
    chk("t2_relock_totalhor", bus.totalhor, 769);

    // Source hsync stops: saturation drops lock, then restart relocks after five edges.
    h_run = 0;
    wait_lock(1'b0, 3000, lc);
    chk("t3_timeout_latency", lc - hfall_cyc, 2051);
    @(negedge clk);
    hper = 1536;
    fb = hfall_cnt;
    h_run = 1;
    wait_fall(fb + 4, fe);
    repeat (6) @(posedge clk);
    #2;
    chk("t3_unlocked_after_4_edges", bus.locked, 0);
    wait_fall(fb + 5, fe);
    wait_lock(1'b1, 1600, lc);
    chk("t3_relock_latency", lc - fe, 3);
    wait_fall(fb + 7, fe);

    // Mid-line reset, then a source period below the minimum.
    repeat (300) @(negedge clk);
    rst = 1'b1;
    h_run = 0;
    #1;
    chk("t6_reset_locked", bus.locked, 0);
    chk("t6_reset_addrread", bus.addrread, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hper = 100; hlow = 40; h_run = 1;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 0; i < 5100; i++) begin
      @(negedge clk);
      if (bus.locked) cnt_a++;
      if (!bus.hsync) cnt_b++;
      if (!bus.vsync) cnt_c++;
      if (i == 2000) vsync_ext_n = 1'b0;
      else if (i == 2300) vsync_ext_n = 1'b1;
    end
    chk("t6_never_locked", cnt_a, 0);
    chk("t6_hsync_idle", cnt_b, 0);
    chk("t6_vsync_idle", cnt_c, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
